vk_arbiter: RTL and testbench

Arbiter and sequencer for the single shared video/keyboard memory port. It shares one synchronous single-port RAM between three requesters: the VGA character fetcher (reads), the PS/2 keyboard decoder (writes through a small FIFO to a fixed mailbox address) and the CPU (reads and writes). It sits between the `vga`/`key` units and the memory, and replaces any combinational address muxing on that port.

---
 rtl/vk_arbiter.sv | 81 ++++++++
 tb/tb_vk_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vk_arbiter.sv
// vk_arbiter: shares one synchronous RAM port between VGA reads, keyboard mailbox writes and CPU accesses
module vk_arbiter #(
  parameter logic [31:0] KEY_ADDR = 32'h0000_20D0,
  parameter int FIFO_DEPTH = 4,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [31:0] vga_rdata,
  input  logic        key_valid,
  input  logic [31:0] key_ascii,
  output logic        key_ready,
  output logic [7:0]  key_drops,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wren,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [2:0] MAX_W = CPU_MAX_WAIT[2:0];
  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU} tag_t;
  logic [31:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [2:0] cpu_wait;
  tag_t tag;
  logic full, empty, cpu_urgent, key_gnt, push;
  always_comb begin
    full = count == DEPTH_C;
    empty = count == '0;
    cpu_urgent = cpu_wait >= MAX_W;
    key_ready = !full;
    push = key_valid & !full;
    vga_gnt = rst & vga_req;
    key_gnt = rst & !vga_req & !empty & !(cpu_req & cpu_urgent);
    cpu_gnt = rst & cpu_req & !vga_req & (empty | cpu_urgent);
    vga_rdata = vga_rvalid ? mem_rdata : '0;
    cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge sys_clk)
    if (push) fifo[wr_ptr] <= key_ascii;
  // The tag travels with mem_* so the read data returning a cycle later is routed to its requester
  always_ff @(posedge sys_clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cpu_wait <= '0;
      key_drops <= '0;
      mem_addr <= '0;
      mem_wren <= 1'b0;
      mem_wdata <= '0;
      tag <= TAG_NONE;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (key_gnt) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, key_gnt};
      if (key_valid && full && key_drops != 8'hFF) key_drops <= key_drops + 8'd1;
      cpu_wait <= (!cpu_req || cpu_gnt) ? 3'd0 : (cpu_wait == 3'd7 ? 3'd7 : cpu_wait + 3'd1);
      mem_addr <= vga_gnt ? vga_addr : key_gnt ? KEY_ADDR : cpu_gnt ? cpu_addr : mem_addr;
      mem_wren <= key_gnt | (cpu_gnt & cpu_we);
      mem_wdata <= key_gnt ? fifo[rd_ptr] : (cpu_gnt & cpu_we) ? cpu_wdata : mem_wdata;
      tag <= vga_gnt ? TAG_VGA : (cpu_gnt & !cpu_we) ? TAG_CPU : TAG_NONE;
      vga_rvalid <= tag == TAG_VGA;
      cpu_rvalid <= tag == TAG_CPU;
    end
endmodule

// File: tb/tb_vk_arbiter.sv
// tb_vk_arbiter: directed scenarios plus a randomized run against a queue-based model of the arbiter
module tb_vk_arbiter;
  localparam logic [31:0] KEY = 32'h0000_20D0;
  logic sys_clk = 0, rst = 0;
  logic vga_req = 0, vga_gnt, vga_rvalid;
  logic [31:0] vga_addr = 0, vga_rdata;
  logic key_valid = 0, key_ready;
  logic [31:0] key_ascii = 0;
  logic [7:0] key_drops;
  logic cpu_req = 0, cpu_we = 0, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic mem_wren;
  int checks = 0, errors = 0;

  vk_arbiter dut (
    .sys_clk(sys_clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .key_valid(key_valid), .key_ascii(key_ascii), .key_ready(key_ready), .key_drops(key_drops),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  // RAM contents are a fixed function of the address, so expected read data needs no storage
  function automatic logic [31:0] base(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always @(posedge sys_clk) mem_rdata <= base(mem_addr);

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    vga_req = 0; key_valid = 0; cpu_req = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    vga_req = 1; cpu_req = 1; vga_addr = 32'h5; cpu_addr = 32'h6;
    tick(); tick();
    #1;
    checks++; if (vga_gnt !== 1'b0) begin errors++; $display("FAIL rst vga_gnt got %b exp 0", vga_gnt); end
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst cpu_gnt got %b exp 0", cpu_gnt); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rst mem_wren got %b exp 0", mem_wren); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst mem_wdata got %h exp 0", mem_wdata); end
    checks++; if ({vga_rvalid, cpu_rvalid} !== 2'b00) begin errors++; $display("FAIL rst rvalid got %b exp 00", {vga_rvalid, cpu_rvalid}); end
    checks++; if ({vga_rdata, cpu_rdata} !== 64'h0) begin errors++; $display("FAIL rst rdata got %h exp 0", {vga_rdata, cpu_rdata}); end
    checks++; if (key_drops !== 8'h0) begin errors++; $display("FAIL rst key_drops got %0d exp 0", key_drops); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst key_ready got %b exp 1", key_ready); end
    vga_req = 0; cpu_req = 0; rst = 1;
    tick();
  endtask

  task automatic test_vga_burst();
    for (int i = 0; i < 6; i++) begin
      vga_req = i < 3; vga_addr = 32'h10 + i;
      #1;
      checks++; if (vga_gnt !== (i < 3)) begin errors++; $display("FAIL burst vga_gnt c%0d got %b exp %b", i, vga_gnt, i < 3); end
      if (i >= 1 && i <= 3) begin
        checks++; if (mem_addr !== 32'h10 + i - 1 || mem_wren !== 1'b0) begin errors++; $display("FAIL burst mem c%0d got %h/%b exp %h/0", i, mem_addr, mem_wren, 32'h10 + i - 1); end
      end
      if (i >= 2) begin
        checks++; if (vga_rvalid !== (i < 5)) begin errors++; $display("FAIL burst vga_rvalid c%0d got %b exp %b", i, vga_rvalid, i < 5); end
      end
      if (i >= 2 && i < 5) begin
        checks++; if (vga_rdata !== base(32'h10 + i - 2)) begin errors++; $display("FAIL burst vga_rdata c%0d got %h exp %h", i, vga_rdata, base(32'h10 + i - 2)); end
      end
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL burst cpu_rvalid c%0d got %b exp 0", i, cpu_rvalid); end
      tick();
    end
  endtask

  task automatic test_key_write();
    for (int i = 0; i < 4; i++) begin
      key_valid = i == 0; key_ascii = 32'h41;
      #1;
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL key key_ready c%0d got %b exp 1", i, key_ready); end
      checks++; if (mem_wren !== (i == 2)) begin errors++; $display("FAIL key mem_wren c%0d got %b exp %b", i, mem_wren, i == 2); end
      if (i >= 2) begin
        checks++; if (mem_addr !== KEY) begin errors++; $display("FAIL key mem_addr c%0d got %h exp %h", i, mem_addr, KEY); end
      end
      if (i == 2) begin
        checks++; if (mem_wdata !== 32'h41) begin errors++; $display("FAIL key mem_wdata got %h exp 41", mem_wdata); end
      end
      if (i == 3) begin
        checks++; if ({vga_rvalid, cpu_rvalid} !== 2'b00) begin errors++; $display("FAIL key rvalid got %b exp 00", {vga_rvalid, cpu_rvalid}); end
      end
      tick();
    end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 6; i++) begin
      vga_req = 1; vga_addr = 32'h30; key_valid = 1; key_ascii = 32'h61 + i;
      #1;
      checks++; if (key_ready !== (i < 4)) begin errors++; $display("FAIL full key_ready c%0d got %b exp %b", i, key_ready, i < 4); end
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      vga_req = 0; key_valid = 0;
      #1;
      if (j == 0) begin
        checks++; if (key_drops !== 8'd2) begin errors++; $display("FAIL full key_drops got %0d exp 2", key_drops); end
      end
      checks++; if (key_ready !== (j != 0)) begin errors++; $display("FAIL drain key_ready c%0d got %b exp %b", j, key_ready, j != 0); end
      checks++; if (mem_wren !== (j >= 1 && j <= 4)) begin errors++; $display("FAIL drain mem_wren c%0d got %b exp %b", j, mem_wren, j >= 1 && j <= 4); end
      if (j >= 1 && j <= 4) begin
        checks++; if (mem_addr !== KEY || mem_wdata !== 32'h61 + j - 1) begin errors++; $display("FAIL drain mem c%0d got %h/%h exp %h/%h", j, mem_addr, mem_wdata, KEY, 32'h61 + j - 1); end
      end
      tick();
    end
  endtask

  task automatic test_cpu_starve();
    key_valid = 1; key_ascii = 32'h80;
    tick();
    for (int i = 0; i < 8; i++) begin
      key_valid = 1; key_ascii = 32'h81 + i; cpu_req = i <= 4; cpu_we = 0; cpu_addr = 32'h100;
      #1;
      checks++; if (cpu_gnt !== (i == 4)) begin errors++; $display("FAIL starve cpu_gnt c%0d got %b exp %b", i, cpu_gnt, i == 4); end
      checks++; if (mem_wren !== (i != 0 && i != 5)) begin errors++; $display("FAIL starve mem_wren c%0d got %b exp %b", i, mem_wren, i != 0 && i != 5); end
      if (i >= 1 && i <= 4) begin
        checks++; if (mem_wdata !== 32'h80 + i - 1) begin errors++; $display("FAIL starve mem_wdata c%0d got %h exp %h", i, mem_wdata, 32'h80 + i - 1); end
      end
      if (i == 5) begin
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL starve mem_addr got %h exp 100", mem_addr); end
      end
      checks++; if (cpu_rvalid !== (i == 6)) begin errors++; $display("FAIL starve cpu_rvalid c%0d got %b exp %b", i, cpu_rvalid, i == 6); end
      if (i == 6) begin
        checks++; if (cpu_rdata !== base(32'h100)) begin errors++; $display("FAIL starve cpu_rdata got %h exp %h", cpu_rdata, base(32'h100)); end
      end
      tick();
    end
    idle(4);
  endtask

  task automatic test_mixed();
    for (int i = 0; i < 6; i++) begin
      vga_req = i == 0; vga_addr = 32'h40; key_valid = i == 0; key_ascii = 32'h77;
      cpu_req = i <= 2; cpu_we = 0; cpu_addr = 32'h200;
      #1;
      checks++; if (vga_gnt !== (i == 0)) begin errors++; $display("FAIL mixed vga_gnt c%0d got %b exp %b", i, vga_gnt, i == 0); end
      checks++; if (cpu_gnt !== (i == 2)) begin errors++; $display("FAIL mixed cpu_gnt c%0d got %b exp %b", i, cpu_gnt, i == 2); end
      checks++; if (mem_wren !== (i == 2)) begin errors++; $display("FAIL mixed mem_wren c%0d got %b exp %b", i, mem_wren, i == 2); end
      if (i == 2) begin
        checks++; if (mem_addr !== KEY || mem_wdata !== 32'h77) begin errors++; $display("FAIL mixed key write got %h/%h exp %h/77", mem_addr, mem_wdata, KEY); end
        checks++; if (vga_rdata !== base(32'h40)) begin errors++; $display("FAIL mixed vga_rdata got %h exp %h", vga_rdata, base(32'h40)); end
      end
      checks++; if (vga_rvalid !== (i == 2)) begin errors++; $display("FAIL mixed vga_rvalid c%0d got %b exp %b", i, vga_rvalid, i == 2); end
      checks++; if (cpu_rvalid !== (i == 4)) begin errors++; $display("FAIL mixed cpu_rvalid c%0d got %b exp %b", i, cpu_rvalid, i == 4); end
      if (i == 4) begin
        checks++; if (cpu_rdata !== base(32'h200)) begin errors++; $display("FAIL mixed cpu_rdata got %h exp %h", cpu_rdata, base(32'h200)); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      vga_req = 1; vga_addr = 32'h50 + i; key_valid = i < 5; key_ascii = i;
      tick();
    end
    vga_req = 0; key_valid = 0; rst = 0;
    #1;
    checks++; if ({mem_addr, mem_wdata} !== 64'h0 || mem_wren !== 1'b0) begin errors++; $display("FAIL rstmid mem got %h/%h/%b exp 0", mem_addr, mem_wdata, mem_wren); end
    checks++; if ({vga_rvalid, cpu_rvalid} !== 2'b00 || {vga_rdata, cpu_rdata} !== 64'h0) begin errors++; $display("FAIL rstmid read outputs got %b/%h exp 0", {vga_rvalid, cpu_rvalid}, {vga_rdata, cpu_rdata}); end
    checks++; if (key_drops !== 8'h0 || key_ready !== 1'b1) begin errors++; $display("FAIL rstmid key got %0d/%b exp 0/1", key_drops, key_ready); end
    tick(); tick();
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (vga_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid vga_rvalid c%0d got %b exp 0", i, vga_rvalid); end
      checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rstmid mem_wren c%0d got %b exp 0", i, mem_wren); end
      checks++; if (key_ready !== 1'b1 || key_drops !== 8'h0) begin errors++; $display("FAIL rstmid fifo c%0d got %b/%0d exp 1/0", i, key_ready, key_drops); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int wt = 0, drops = 0, t1 = 0, t2 = 0;
    logic cp = 0, w1 = 0, ev, ek, ec, full_b;
    logic [31:0] a1 = 0, a2 = 0, d1 = 0;
    for (int i = 0; i < 400; i++) begin
      vga_req = $urandom_range(0, 2) == 0; vga_addr = $urandom_range(0, 32'hFFFF);
      if (!cp) begin
        cpu_req = $urandom_range(0, 1) == 1; cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = $urandom_range(0, 32'hFFFF); cpu_wdata = $urandom;
      end
      key_valid = $urandom_range(0, 1) == 1; key_ascii = $urandom;
      full_b = q.size() == 4;
      ev = vga_req;
      ek = !vga_req && q.size() != 0 && !(cpu_req && wt >= 4);
      ec = cpu_req && !vga_req && (q.size() == 0 || wt >= 4);
      #1;
      checks++; if (vga_gnt !== ev) begin errors++; $display("FAIL rnd vga_gnt c%0d got %b exp %b", i, vga_gnt, ev); end
      checks++; if (cpu_gnt !== ec) begin errors++; $display("FAIL rnd cpu_gnt c%0d got %b exp %b", i, cpu_gnt, ec); end
      checks++; if (key_ready !== !full_b) begin errors++; $display("FAIL rnd key_ready c%0d got %b exp %b", i, key_ready, !full_b); end
      checks++; if (key_drops !== 8'(drops)) begin errors++; $display("FAIL rnd key_drops c%0d got %0d exp %0d", i, key_drops, drops); end
      checks++; if (mem_wren !== w1 || mem_addr !== a1) begin errors++; $display("FAIL rnd mem c%0d got %b/%h exp %b/%h", i, mem_wren, mem_addr, w1, a1); end
      if (w1) begin
        checks++; if (mem_wdata !== d1) begin errors++; $display("FAIL rnd mem_wdata c%0d got %h exp %h", i, mem_wdata, d1); end
      end
      checks++; if (vga_rvalid !== (t2 == 1) || cpu_rvalid !== (t2 == 2)) begin errors++; $display("FAIL rnd rvalid c%0d got %b%b exp tag %0d", i, vga_rvalid, cpu_rvalid, t2); end
      if (t2 != 0) begin
        checks++; if ((t2 == 1 ? vga_rdata : cpu_rdata) !== base(a2)) begin errors++; $display("FAIL rnd rdata c%0d got %h exp %h", i, t2 == 1 ? vga_rdata : cpu_rdata, base(a2)); end
      end
      t2 = t1; a2 = a1;
      if (ev) begin a1 = vga_addr; w1 = 0; t1 = 1; end
      else if (ek) begin a1 = KEY; w1 = 1; d1 = q.pop_front(); t1 = 0; end
      else if (ec) begin a1 = cpu_addr; w1 = cpu_we; if (cpu_we) d1 = cpu_wdata; t1 = cpu_we ? 0 : 2; end
      else begin w1 = 0; t1 = 0; end
      if (key_valid && !full_b) q.push_back(key_ascii);
      else if (key_valid && drops < 255) drops++;
      wt = (!cpu_req || ec) ? 0 : (wt < 7 ? wt + 1 : 7);
      cp = cpu_req && !ec;
      tick();
    end
    idle(4);
  endtask

  initial begin
    tick();
    test_reset();
    test_vga_burst();
    test_key_write();
    test_fifo_full();
    test_cpu_starve();
    test_mixed();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
